// File: rtl/map_req_arbiter_pkg.sv
// Shared game package: map-request arbiter FSM encoding, default channel widths and the
// request-type codes understood by the map controller (shared with digger and bullet blocks).
package map_req_arbiter_pkg;

   localparam int unsigned MapTypeW    = 2;
   localparam int unsigned MapContentW = 8;
   localparam int unsigned MapDataW    = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StDone  = 2'd3
   } arb_state_e;

   // Map-cell request codes carried on req_type / mem_type.
   localparam logic [MapTypeW-1:0] ReqRead  = 2'd0;
   localparam logic [MapTypeW-1:0] ReqWrite = 2'd1;
   localparam logic [MapTypeW-1:0] ReqDig   = 2'd2;
   localparam logic [MapTypeW-1:0] ReqHit   = 2'd3;

endpackage

// File: rtl/map_req_arbiter_rr_pick.sv
// Combinational round-robin first-one finder.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the most recent grantee; the scan starts at ptr+1 and wraps
//   grant - index of the first set request found
//   valid - high when any request is set
module map_req_arbiter_rr_pick #(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [$clog2(N_REQ)-1:0] grant,
   output logic                     valid
);

   localparam int unsigned IdW = $clog2(N_REQ);

   int unsigned    idx;
   logic [IdW-1:0] cand;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      cand  = '0;
      // off = N_REQ lands back on ptr itself, so the last grantee has lowest priority.
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         idx = 32'(ptr) + off;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         cand = IdW'(idx);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            grant = cand;
         end
      end
   end

endmodule

// File: rtl/map_req_arbiter.sv
// Map-memory request arbiter: shares one map-controller request channel between several
// game-object requesters (0 = digger, 1 = bullet, 2.. = enemies) in round-robin order.
// Ports:
//   clk, rst                     - clock and synchronous active-low reset
//   req, req_type, req_content   - per-requester request bits and packed type/content slices
//   ack, nack, wr, data_out      - one-cycle response pulses to the grantee and shared data
//   mem_req, mem_type, mem_content - request strobe and latched request to the map controller
//   mem_ack, mem_nack, mem_wr, mem_data - map controller response
//   busy, grant_id               - transaction in progress, current/most recent grantee
module map_req_arbiter
   import map_req_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned TYPE_W    = MapTypeW,
   parameter int unsigned CONTENT_W = MapContentW,
   parameter int unsigned DATA_W    = MapDataW,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ*TYPE_W-1:0]      req_type,
   input  logic [N_REQ*CONTENT_W-1:0]   req_content,
   output logic [N_REQ-1:0]             ack,
   output logic [N_REQ-1:0]             nack,
   output logic [N_REQ-1:0]             wr,
   output logic [DATA_W-1:0]            data_out,
   output logic                         mem_req,
   output logic [TYPE_W-1:0]            mem_type,
   output logic [CONTENT_W-1:0]         mem_content,
   input  logic                         mem_ack,
   input  logic                         mem_nack,
   input  logic                         mem_wr,
   input  logic [DATA_W-1:0]            mem_data,
   output logic                         busy,
   output logic [$clog2(N_REQ)-1:0]     grant_id
);

   localparam int unsigned IdW  = $clog2(N_REQ);
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   arb_state_e           state_q, state_d;
   logic [IdW-1:0]       ptr_q, grant_q, pick_grant;
   logic                 pick_valid;
   logic [TYPE_W-1:0]    type_q, sel_type;
   logic [CONTENT_W-1:0] content_q, sel_content;
   logic [CntW-1:0]      cnt_q;
   logic [N_REQ-1:0]     ack_q, nack_q, wr_q, grant_oh;
   logic [DATA_W-1:0]    data_q;
   logic                 timeout_hit;

   map_req_arbiter_rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   // Slice out the type/content of the requester about to be granted.
   always_comb begin
      sel_type    = '0;
      sel_content = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (pick_grant == IdW'(i)) begin
            sel_type    = req_type[i*TYPE_W +: TYPE_W];
            sel_content = req_content[i*CONTENT_W +: CONTENT_W];
         end
      end
   end

   // Last WAIT cycle: counter started at 0 on WAIT entry, so WAIT lasts TIMEOUT cycles.
   assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
   assign grant_oh    = N_REQ'(1) << grant_q;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (pick_valid) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait:  if (mem_ack || mem_nack || timeout_hit) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Moore outputs.
   always_comb begin
      mem_req = (state_q == StIssue);
      busy    = (state_q != StIdle);
   end

   // Grant latches, timeout counter and response pulses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q     <= IdW'(N_REQ - 1);
         grant_q   <= '0;
         type_q    <= '0;
         content_q <= '0;
         cnt_q     <= '0;
         ack_q     <= '0;
         nack_q    <= '0;
         wr_q      <= '0;
         data_q    <= '0;
      end else begin
         ack_q  <= '0;
         nack_q <= '0;
         wr_q   <= '0;
         unique case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  grant_q   <= pick_grant;
                  ptr_q     <= pick_grant;
                  type_q    <= sel_type;
                  content_q <= sel_content;
               end
            end
            StIssue: cnt_q <= '0;
            StWait: begin
               cnt_q <= cnt_q + CntW'(1);
               // ack wins over nack; a real response in the last cycle beats the timeout.
               if (mem_ack) begin
                  ack_q <= grant_oh;
                  if (mem_wr) begin
                     wr_q   <= grant_oh;
                     data_q <= mem_data;
                  end
               end else if (mem_nack || timeout_hit) begin
                  nack_q <= grant_oh;
               end
            end
            default: ;
         endcase
      end
   end

   assign ack         = ack_q;
   assign nack        = nack_q;
   assign wr          = wr_q;
   assign data_out    = data_q;
   assign mem_type    = type_q;
   assign mem_content = content_q;
   assign grant_id    = grant_q;

endmodule
